// File: rtl/pipeline_exec_controller.sv
// Execution sequencer for the 5-stage MIPS pipeline under debug control.
// Handles RUN/STEP/ABORT, detects HALT in IF, drains older instructions, then parks.
module pipeline_exec_controller #(
    parameter int                   NB           = 32,
    parameter int                   NB_OPCODE    = 6,
    parameter int                   NB_CYCLES    = 32,
    parameter int                   DRAIN_CYCLES = 4,
    parameter logic [NB_OPCODE-1:0] HALT_OPCODE  = 6'h3F
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_cmd_valid,
    input  logic [1:0]           i_cmd,
    output logic                 o_cmd_ready,
    input  logic [NB-1:0]        i_if_instruction,
    output logic                 o_pipeline_enable,
    output logic                 o_flush,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_halted,
    output logic [NB_CYCLES-1:0] o_cycle_count,
    output logic [2:0]           o_state
);

    localparam int NB_DRAIN = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [NB_DRAIN-1:0] DRAIN_LAST = NB_DRAIN'(DRAIN_CYCLES - 1);

    localparam logic [1:0] CMD_RUN   = 2'b01;
    localparam logic [1:0] CMD_STEP  = 2'b10;
    localparam logic [1:0] CMD_ABORT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [NB_DRAIN-1:0]   drain_q, drain_d;
    logic [NB_CYCLES-1:0]  count_q, count_d;
    logic                  done_q, done_d;
    logic                  flush_q, flush_d;

    logic enable;
    logic ready;
    logic accept;
    logic abort;
    logic halt_fetch;
    logic unused_instr_bits;

    assign unused_instr_bits = ^i_if_instruction[NB-NB_OPCODE-1:0];

    always_comb begin
        enable     = (state_q == ST_RUN) || (state_q == ST_STEP) || (state_q == ST_DRAIN);
        ready      = (state_q == ST_IDLE) || (state_q == ST_RUN) || (state_q == ST_HALTED);
        accept     = i_cmd_valid && ready;
        abort      = accept && (i_cmd == CMD_ABORT);
        halt_fetch = enable && (i_if_instruction[NB-1 -: NB_OPCODE] == HALT_OPCODE);
    end

    // Next-state logic; the drain counter holds the number of drain cycles still to go after this one
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        count_d = count_q;
        done_d  = 1'b0;
        flush_d = 1'b0;

        if (abort) begin
            count_d = '0;
        end else if (enable && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept && (i_cmd == CMD_RUN)) begin
                    state_d = ST_RUN;
                end else if (accept && (i_cmd == CMD_STEP)) begin
                    state_d = ST_STEP;
                end else if (abort) begin
                    flush_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    flush_d = 1'b1;
                end else if (halt_fetch) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_LAST;
                end
            end
            ST_STEP: begin
                if (halt_fetch) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_LAST;
                end else begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = ST_HALTED;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            ST_HALTED: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    flush_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            drain_q <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            count_q <= count_d;
            done_q  <= done_d;
            flush_q <= flush_d;
        end
    end

    // Every output is forced low while reset is held, even before the first sampling edge
    always_comb begin
        o_cmd_ready       = i_reset && ready;
        o_pipeline_enable = i_reset && enable;
        o_busy            = i_reset && enable;
        o_halted          = i_reset && (state_q == ST_HALTED);
        o_done            = i_reset && done_q;
        o_flush           = i_reset && flush_q;
        o_cycle_count     = i_reset ? count_q : '0;
        o_state           = i_reset ? 3'(state_q) : 3'd0;
    end

endmodule

// File: tb/tb_pipeline_exec_controller.sv
// Self-checking bench for pipeline_exec_controller: directed scenarios plus random traffic
// compared every cycle against a transaction-level reference model.
module tb_pipeline_exec_controller;

    localparam logic [31:0] ADD_INSTR  = 32'h0022_1820;
    localparam logic [31:0] HALT_INSTR = 32'hFC00_0000;
    localparam logic [1:0]  NOP = 2'b00, RUN = 2'b01, STEP = 2'b10, ABORT = 2'b11;
    localparam longint      MAX_A = 64'hFFFF_FFFF;
    localparam longint      MAX_B = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic [1:0]  cmd;
    logic [31:0] instr;

    logic        ready_a, en_a, flush_a, busy_a, done_a, halted_a;
    logic [31:0] count_a;
    logic [2:0]  state_a;
    logic        ready_b, en_b, flush_b, busy_b, done_b, halted_b;
    logic [3:0]  count_b;
    logic [2:0]  state_b;

    int checks   = 0;
    int failures = 0;

    // Reference model: phase code, remaining drain cycles, pending pulses and counts
    int     m_state;
    int     m_drain_left;
    longint m_cnt_a;
    longint m_cnt_b;
    bit     m_done;
    bit     m_flush;

    always #5 clk = ~clk;

    pipeline_exec_controller dut_a (
        .i_clk             (clk),
        .i_reset           (rst_n),
        .i_cmd_valid       (cmd_valid),
        .i_cmd             (cmd),
        .o_cmd_ready       (ready_a),
        .i_if_instruction  (instr),
        .o_pipeline_enable (en_a),
        .o_flush           (flush_a),
        .o_busy            (busy_a),
        .o_done            (done_a),
        .o_halted          (halted_a),
        .o_cycle_count     (count_a),
        .o_state           (state_a)
    );

    pipeline_exec_controller #(.NB_CYCLES(4)) dut_b (
        .i_clk             (clk),
        .i_reset           (rst_n),
        .i_cmd_valid       (cmd_valid),
        .i_cmd             (cmd),
        .o_cmd_ready       (ready_b),
        .i_if_instruction  (instr),
        .o_pipeline_enable (en_b),
        .o_flush           (flush_b),
        .o_busy            (busy_b),
        .o_done            (done_b),
        .o_halted          (halted_b),
        .o_cycle_count     (count_b),
        .o_state           (state_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit en, rdy, abort, halt;
        if (!rst_n) begin
            m_state = 0; m_drain_left = 0; m_cnt_a = 0; m_cnt_b = 0; m_done = 0; m_flush = 0;
        end else begin
            en    = (m_state >= 1) && (m_state <= 3);
            rdy   = (m_state == 0) || (m_state == 1) || (m_state == 4);
            abort = cmd_valid && rdy && (cmd == ABORT);
            halt  = (instr[31:26] == 6'h3F);
            m_done  = 0;
            m_flush = 0;
            if (abort) begin
                m_cnt_a = 0; m_cnt_b = 0;
            end else if (en) begin
                if (m_cnt_a < MAX_A) m_cnt_a++;
                if (m_cnt_b < MAX_B) m_cnt_b++;
            end
            case (m_state)
                0: if (cmd_valid) begin
                       if (cmd == RUN) m_state = 1;
                       else if (cmd == STEP) m_state = 2;
                       else if (cmd == ABORT) m_flush = 1;
                   end
                1: if (abort) begin m_state = 0; m_flush = 1; end
                   else if (halt) begin m_state = 3; m_drain_left = 4; end
                2: if (halt) begin m_state = 3; m_drain_left = 4; end
                   else begin m_state = 0; m_done = 1; end
                3: begin
                       m_drain_left--;
                       if (m_drain_left == 0) begin m_state = 4; m_done = 1; end
                   end
                4: if (abort) begin m_state = 0; m_flush = 1; end
                default: m_state = 0;
            endcase
        end
    endtask

    task automatic check_model();
        bit busy_exp;
        busy_exp = rst_n && (m_state >= 1) && (m_state <= 3);
        check("ready_a",  ready_a,  rst_n && (m_state == 0 || m_state == 1 || m_state == 4));
        check("enable_a", en_a,     busy_exp);
        check("busy_a",   busy_a,   busy_exp);
        check("halted_a", halted_a, rst_n && (m_state == 4));
        check("done_a",   done_a,   rst_n && m_done);
        check("flush_a",  flush_a,  rst_n && m_flush);
        check("count_a",  count_a,  rst_n ? m_cnt_a : 0);
        check("state_a",  state_a,  rst_n ? m_state : 0);
        check("enable_b", en_b,     busy_exp);
        check("done_b",   done_b,   rst_n && m_done);
        check("count_b",  count_b,  rst_n ? m_cnt_b : 0);
        check("state_b",  state_b,  rst_n ? m_state : 0);
    endtask

    task automatic applyStimulus(input bit r, input bit v, input logic [1:0] c, input logic [31:0] ins);
        rst_n = r; cmd_valid = v; cmd = c; instr = ins;
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    initial begin
        int en_cycles;
        int seen_done;
        logic [31:0] rins;

        rst_n = 0; cmd_valid = 1; cmd = RUN; instr = ADD_INSTR;
        m_state = 0; m_drain_left = 0; m_cnt_a = 0; m_cnt_b = 0; m_done = 0; m_flush = 0;

        $display("[TB] reset held with RUN offered");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, RUN, ADD_INSTR);
            check("rst_enable", en_a, 0);
            check("rst_state", state_a, 0);
            check("rst_count", count_a, 0);
        end
        applyStimulus(1, 0, NOP, ADD_INSTR);
        check("release_ready", ready_a, 1);

        $display("[TB] three single steps");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, STEP, ADD_INSTR);
            check("step_enable", en_a, 1);
            check("step_ready", ready_a, 0);
            applyStimulus(1, 0, NOP, ADD_INSTR);
            check("step_done", done_a, 1);
            check("step_enable_off", en_a, 0);
        end
        check("step_count", count_a, 3);

        $display("[TB] run to HALT and drain");
        applyStimulus(1, 1, ABORT, ADD_INSTR);
        applyStimulus(1, 1, RUN, ADD_INSTR);
        en_cycles = 0;
        seen_done = 0;
        for (int i = 0; i < 40 && !halted_a; i++) begin
            rins = (en_cycles == 10) ? HALT_INSTR : ADD_INSTR;
            if (en_a) en_cycles++;
            applyStimulus(1, 0, NOP, rins);
            if (done_a) seen_done++;
        end
        check("run_enabled_cycles", en_cycles, 15);
        check("run_done_pulses", seen_done, 1);
        check("run_halted", halted_a, 1);
        check("run_count", count_a, 15);

        $display("[TB] commands while halted");
        applyStimulus(1, 1, RUN, ADD_INSTR);
        check("halted_run_ignored", state_a, 4);
        applyStimulus(1, 1, STEP, ADD_INSTR);
        check("halted_step_ignored", state_a, 4);
        applyStimulus(1, 1, ABORT, ADD_INSTR);
        check("abort_state", state_a, 0);
        check("abort_flush", flush_a, 1);
        check("abort_count", count_a, 0);
        applyStimulus(1, 0, NOP, ADD_INSTR);
        check("abort_flush_one_cycle", flush_a, 0);

        $display("[TB] abort mid-run and reset mid-drain");
        applyStimulus(1, 1, RUN, ADD_INSTR);
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, NOP, ADD_INSTR);
        applyStimulus(1, 1, ABORT, ADD_INSTR);
        check("run_abort_enable", en_a, 0);
        check("run_abort_flush", flush_a, 1);
        check("run_abort_count", count_a, 0);
        applyStimulus(1, 1, RUN, ADD_INSTR);
        applyStimulus(1, 0, NOP, HALT_INSTR);
        check("drain_entered", state_a, 3);
        applyStimulus(1, 0, NOP, ADD_INSTR);
        applyStimulus(0, 0, NOP, ADD_INSTR);
        applyStimulus(1, 0, NOP, ADD_INSTR);
        check("drain_reset_state", state_a, 0);
        check("drain_reset_count", count_a, 0);
        check("drain_reset_done", done_a, 0);

        $display("[TB] 4-bit counter saturation and step into HALT");
        applyStimulus(1, 1, RUN, ADD_INSTR);
        for (int i = 0; i < 20; i++) applyStimulus(1, 0, NOP, ADD_INSTR);
        check("sat_count_b", count_b, 15);
        check("nosat_count_a", count_a, 20);
        applyStimulus(1, 1, ABORT, ADD_INSTR);
        applyStimulus(1, 1, STEP, ADD_INSTR);
        applyStimulus(1, 0, NOP, HALT_INSTR);
        check("step_halt_drain", state_b, 3);
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, NOP, ADD_INSTR);
        check("step_halt_state", state_b, 4);
        check("step_halt_count", count_b, 5);
        check("step_halt_done", done_b, 1);

        $display("[TB] random traffic");
        for (int i = 0; i < 800; i++) begin
            rins = $urandom;
            if ($urandom_range(0, 7) == 0) rins[31:26] = 6'h3F;
            applyStimulus(($urandom_range(0, 39) != 0), 1'($urandom_range(0, 1)),
                          2'($urandom_range(0, 3)), rins);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
